// File: rtl/spi_accel_slave.sv
// SPI slave modelling a byte-addressed accelerometer register file.
// All SPI pins are oversampled in the clk domain. Axis samples arriving
// during a frame are held back and committed on CS rise so burst reads stay coherent.
//
// state    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | CS high, or waiting for a clean CS fall after reset
// S_CMD    | shifting in the command byte
// S_ADDR   | shifting in the start address
// S_READ   | shifting out reg[addr], auto-increment per byte
// S_WRITE  | shifting in data bytes, auto-increment per byte
// S_IGNORE | unknown command, MISO held 0 until CS high
module spi_accel_slave #(
    parameter int         NUM_REGS  = 64,
    parameter int         NUM_AXES  = 3,
    parameter logic [7:0] AXIS_BASE = 8'h0E,
    parameter logic [7:0] DEVID     = 8'hAD,
    parameter bit         CPOL      = 1'b0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   SCLK,
    input  logic                   CS,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic                   sample_valid,
    input  logic [16*NUM_AXES-1:0] sample_data,
    output logic                   INT1,
    output logic                   INT2,
    output logic                   wr_strobe,
    output logic [7:0]             wr_addr,
    output logic [7:0]             wr_data
);

    localparam int            AW         = $clog2(NUM_REGS);
    localparam int            BASE_I     = int'(AXIS_BASE) % NUM_REGS;
    localparam logic [AW-1:0] STATUS_A   = AW'(8'h0B);
    localparam logic [AW-1:0] LAST_MSB_A = AW'((BASE_I + 2*NUM_AXES - 1) % NUM_REGS);
    localparam logic [7:0]    CMD_RD     = 8'h0B;
    localparam logic [7:0]    CMD_WR     = 8'h0A;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sclk_s_q, sclk_s_d, cs_s_q, cs_s_d, mosi_s_q, mosi_s_d;
    logic                    sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [6:0]              shin_q, shin_d;
    logic [7:0]              shout_q, shout_d;
    logic                    cmd_rd_q, cmd_rd_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    miso_q, miso_d, dr_q, dr_d, ovr_q, ovr_d;
    logic                    pend_q, pend_d;
    logic [16*NUM_AXES-1:0]  pend_data_q, pend_data_d;
    logic [7:0]              regs_q [NUM_REGS];
    logic [7:0]              regs_d [NUM_REGS];
    logic                    wr_strobe_q, wr_strobe_d;
    logic [7:0]              wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;

    logic                    sclk_n, rise, fall, cs_hi, cs_fall, cs_rise, byte_done, commit;
    logic [7:0]              in_byte;
    logic [AW-1:0]           addr_nxt;
    logic [16*NUM_AXES-1:0]  axis_src;

    function automatic logic is_axis(input logic [AW-1:0] a);
        return ((int'(a) - BASE_I + NUM_REGS) % NUM_REGS) < 2*NUM_AXES;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [AW-1:0] a);
        if (a == '0)
            return DEVID;
        else if (a == STATUS_A)
            return {6'b0, ovr_q, dr_q};
        else
            return regs_q[a];
    endfunction

    // Next-state logic: synchronizers, SPI framing, register file and flags.
    always_comb begin
        sclk_s_d    = {sclk_s_q[0], SCLK};
        cs_s_d      = {cs_s_q[0], CS};
        mosi_s_d    = {mosi_s_q[0], MOSI};
        sclk_n      = sclk_s_q[1] ^ CPOL;
        rise        = sclk_n & ~sclk_prev_q;
        fall        = ~sclk_n & sclk_prev_q;
        cs_hi       = cs_s_q[1];
        cs_fall     = ~cs_hi & cs_prev_q;
        cs_rise     = cs_hi & ~cs_prev_q;
        in_byte     = {shin_q, mosi_s_q[1]};
        byte_done   = rise & (bit_cnt_q == 3'd7);
        addr_nxt    = addr_q + AW'(1);
        sclk_prev_d = sclk_n;
        cs_prev_d   = cs_hi;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        cmd_rd_d    = cmd_rd_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        dr_d        = dr_q;
        ovr_d       = ovr_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        commit      = 1'b0;
        axis_src    = pend_data_q;

        if (cs_hi) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (cs_fall)
                state_d = S_CMD;
        end else begin
            if (rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shin_d    = in_byte[6:0];
            end
            if (fall && state_q == S_READ) begin
                miso_d  = shout_q[7];
                shout_d = {shout_q[6:0], 1'b0};
            end
            if (byte_done) begin
                case (state_q)
                    S_CMD: begin
                        cmd_rd_d = (in_byte == CMD_RD);
                        state_d  = (in_byte == CMD_RD || in_byte == CMD_WR) ? S_ADDR : S_IGNORE;
                    end
                    S_ADDR: begin
                        addr_d  = in_byte[AW-1:0];
                        state_d = cmd_rd_q ? S_READ : S_WRITE;
                        shout_d = rd_byte(in_byte[AW-1:0]);
                    end
                    S_READ: begin
                        if (addr_q == LAST_MSB_A) dr_d  = 1'b0;
                        if (addr_q == STATUS_A)   ovr_d = 1'b0;
                        addr_d  = addr_nxt;
                        shout_d = rd_byte(addr_nxt);
                    end
                    S_WRITE: begin
                        if (addr_q != '0 && addr_q != STATUS_A && !is_axis(addr_q)) begin
                            regs_d[addr_q] = in_byte;
                            wr_strobe_d    = 1'b1;
                            wr_addr_d      = 8'(addr_q);
                            wr_data_d      = in_byte;
                        end
                        addr_d = addr_nxt;
                    end
                    default: ;
                endcase
            end
        end

        // Samples land directly while CS is high, otherwise they wait for CS rise.
        if (cs_rise && pend_q) begin
            commit = 1'b1;
            pend_d = 1'b0;
        end
        if (sample_valid) begin
            if (cs_hi) begin
                commit   = 1'b1;
                axis_src = sample_data;
            end else begin
                if (pend_q) ovr_d = 1'b1;
                pend_d      = 1'b1;
                pend_data_d = sample_data;
            end
        end
        if (commit) begin
            if (dr_q) ovr_d = 1'b1;
            dr_d = 1'b1;
            for (int k = 0; k < NUM_AXES; k++) begin
                regs_d[AW'((BASE_I + 2*k) % NUM_REGS)]     = axis_src[16*k +: 8];
                regs_d[AW'((BASE_I + 2*k + 1) % NUM_REGS)] = axis_src[16*k+8 +: 8];
            end
        end
    end

    // State registers; CS history resets low so a frame in progress is ignored.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sclk_s_q    <= {2{CPOL}};
            cs_s_q      <= 2'b00;
            mosi_s_q    <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            cmd_rd_q    <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            dr_q        <= 1'b0;
            ovr_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sclk_s_q    <= sclk_s_d;
            cs_s_q      <= cs_s_d;
            mosi_s_q    <= mosi_s_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            cmd_rd_q    <= cmd_rd_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            dr_q        <= dr_d;
            ovr_q       <= ovr_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign MISO      = miso_q;
    assign INT1      = dr_q;
    assign INT2      = ovr_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_accel_slave.sv
// Directed bench for spi_accel_slave: a CPOL=0 and a CPOL=1 instance share one
// bit-banged SPI master; read bytes and write strobes are checked against queues.
module tb_spi_accel_slave;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0, sclk_l = 1'b0, cs_l = 1'b1, mosi = 1'b0;
    logic        sv = 1'b0;
    logic [47:0] sdata = '0;
    wire         sclk0, sclk1, cs0, cs1, miso0, miso1, miso_sel;
    wire         int1_0, int2_0, wr_strobe0, int1_1, int2_1, wr_strobe1;
    wire  [7:0]  wr_addr0, wr_data0, wr_addr1, wr_data1;

    int          tests = 0, fails = 0, cyc = 0, last_rise_cyc = 0;
    logic [7:0]  tx_buf [$];
    logic [7:0]  exp_q [$];
    logic [15:0] sb_wr [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sclk0    = sel ? 1'b0 : sclk_l;
    assign sclk1    = sel ? ~sclk_l : 1'b1;
    assign cs0      = sel ? 1'b1 : cs_l;
    assign cs1      = sel ? cs_l : 1'b1;
    assign miso_sel = sel ? miso1 : miso0;

    spi_accel_slave dut0 (
        .clk(clk), .resetn(resetn), .SCLK(sclk0), .CS(cs0), .MOSI(mosi), .MISO(miso0),
        .sample_valid(sv), .sample_data(sdata), .INT1(int1_0), .INT2(int2_0),
        .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .wr_data(wr_data0)
    );

    spi_accel_slave #(.CPOL(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .SCLK(sclk1), .CS(cs1), .MOSI(mosi), .MISO(miso1),
        .sample_valid(1'b0), .sample_data(48'h0), .INT1(int1_1), .INT2(int2_1),
        .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one CS-low frame of nbits from tx_buf; data bytes are popped from exp_q when chk.
    task automatic spi_frame(input bit inst, input int nbits, input bit chk, input string tag);
        logic [7:0] rxb, b;
        logic       m2, m3;
        rxb = '0;
        sel = inst;
        sclk_l = 1'b0;
        @(negedge clk);
        cs_l = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = (i / 8 < tx_buf.size()) ? tx_buf[i / 8] : 8'h00;
            mosi = b[7 - (i % 8)];
            repeat (4) @(negedge clk);
            rxb = {rxb[6:0], miso_sel};
            sclk_l = 1'b1;
            last_rise_cyc = cyc;
            if (chk && i >= 16 && (i % 8) == 7 && exp_q.size() > 0)
                check(tag, {24'h0, rxb}, {24'h0, exp_q.pop_front()});
            repeat (4) @(negedge clk);
            sclk_l = 1'b0;
            if (chk && i == 15 && exp_q.size() > 0) begin
                repeat (2) @(negedge clk);
                m2 = miso_sel;
                @(negedge clk);
                m3 = miso_sel;
                check({tag, "_miso_before"}, {31'h0, m2}, 32'h0);
                check({tag, "_miso_at3"}, {31'h0, m3}, {31'h0, exp_q[0][7]});
            end
        end
        repeat (4) @(negedge clk);
        cs_l = 1'b1;
        repeat (8) @(negedge clk);
        tx_buf.delete();
    endtask

    task automatic sv_pulse(input logic [47:0] d);
        @(negedge clk);
        sdata = d;
        sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    // Strobe scoreboard: every strobe must match the next expected (addr,data), 3 clk after the rise.
    always @(negedge clk) begin
        if (wr_strobe0) begin
            if (sb_wr.size() == 0) begin
                check("wr_unexpected_strobe", {31'h0, wr_strobe0}, 32'h0);
            end else begin
                check("wr_addr_data", {16'h0, wr_addr0, wr_data0}, {16'h0, sb_wr.pop_front()});
                check("wr_latency", cyc - last_rise_cyc, 3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_miso", {31'h0, miso0}, 0);
        check("rst_int1", {31'h0, int1_0}, 0);
        check("rst_int2", {31'h0, int2_0}, 0);
        check("rst_wr_strobe", {31'h0, wr_strobe0}, 0);
        check("rst_wr_addr", {24'h0, wr_addr0}, 0);
        check("rst_wr_data", {24'h0, wr_data0}, 0);
        repeat (4) @(negedge clk);

        // DEVID read
        tx_buf = '{8'h0B, 8'h00}; exp_q.push_back(8'hAD);
        spi_frame(1'b0, 24, 1'b1, "devid");
        check("miso_idle", {31'h0, miso0}, 0);

        // Direct sample load and coherent burst read of Y/Z
        sv_pulse({16'h1400, 16'h0A05, 16'h7F31});
        check("int1_after_sample", {31'h0, int1_0}, 1);
        check("int2_after_sample", {31'h0, int2_0}, 0);
        tx_buf = '{8'h0B, 8'h10};
        exp_q.push_back(8'h05); exp_q.push_back(8'h0A); exp_q.push_back(8'h00); exp_q.push_back(8'h14);
        spi_frame(1'b0, 48, 1'b1, "burst_yz");
        check("int1_cleared", {31'h0, int1_0}, 0);

        // Wrap write: 0x3F accepted, 0x00 ignored
        tx_buf = '{8'h0A, 8'h3F, 8'h11, 8'h22}; sb_wr.push_back({8'h3F, 8'h11});
        spi_frame(1'b0, 32, 1'b0, "wr_wrap");
        tx_buf = '{8'h0B, 8'h3F}; exp_q.push_back(8'h11); exp_q.push_back(8'hAD);
        spi_frame(1'b0, 32, 1'b1, "rd_wrap");

        // STATUS skipped inside a write burst, axis writes ignored
        tx_buf = '{8'h0A, 8'h0A, 8'h77, 8'h88, 8'h99};
        sb_wr.push_back({8'h0A, 8'h77}); sb_wr.push_back({8'h0C, 8'h99});
        spi_frame(1'b0, 40, 1'b0, "wr_status_skip");
        tx_buf = '{8'h0A, 8'h10, 8'hEE};
        spi_frame(1'b0, 24, 1'b0, "wr_axis");
        tx_buf = '{8'h0B, 8'h0A};
        exp_q.push_back(8'h77); exp_q.push_back(8'h00); exp_q.push_back(8'h99);
        spi_frame(1'b0, 40, 1'b1, "rd_0a");
        tx_buf = '{8'h0B, 8'h10}; exp_q.push_back(8'h05);
        spi_frame(1'b0, 24, 1'b1, "rd_axis_kept");

        // Two samples during a read frame: pre-frame values returned, second sample committed
        tx_buf = '{8'h0B, 8'h0E};
        exp_q.push_back(8'h31); exp_q.push_back(8'h7F); exp_q.push_back(8'h05);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h00); exp_q.push_back(8'h14);
        fork
            spi_frame(1'b0, 64, 1'b1, "rd_coherent");
            begin
                repeat (40) @(negedge clk);
                sv_pulse({16'h1111, 16'h2222, 16'h3333});
                repeat (60) @(negedge clk);
                sv_pulse({16'h6655, 16'h4433, 16'h2211});
                check("int1_held_in_frame", {31'h0, int1_0}, 0);
            end
        join
        check("int1_commit", {31'h0, int1_0}, 1);
        check("int2_overrun", {31'h0, int2_0}, 1);
        tx_buf = '{8'h0B, 8'h0B}; exp_q.push_back(8'h03);
        spi_frame(1'b0, 24, 1'b1, "rd_status");
        check("int2_cleared", {31'h0, int2_0}, 0);
        check("int1_kept", {31'h0, int1_0}, 1);
        tx_buf = '{8'h0B, 8'h0E};
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        spi_frame(1'b0, 64, 1'b1, "rd_committed");
        check("int1_cleared2", {31'h0, int1_0}, 0);

        // Partial write byte discarded; unknown command keeps MISO low
        tx_buf = '{8'h0A, 8'h30, 8'hFF};
        spi_frame(1'b0, 21, 1'b0, "wr_partial");
        tx_buf = '{8'h0B, 8'h30}; exp_q.push_back(8'h00);
        spi_frame(1'b0, 24, 1'b1, "rd_partial");
        tx_buf = '{8'h55, 8'h00}; exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_frame(1'b0, 32, 1'b1, "cmd_55");

        // CPOL=1 instance
        tx_buf = '{8'h0B, 8'h00}; exp_q.push_back(8'hAD);
        spi_frame(1'b1, 24, 1'b1, "devid_cpol1");

        // Reset in the middle of a burst
        sv_pulse({16'hA0A0, 16'hB0B0, 16'hC0C0});
        check("int1_pre_reset", {31'h0, int1_0}, 1);
        tx_buf = '{8'h0B, 8'h0E};
        fork
            spi_frame(1'b0, 64, 1'b0, "rd_aborted");
            begin
                repeat (200) @(negedge clk);
                resetn = 1'b0;
                @(negedge clk);
                check("mid_rst_miso", {31'h0, miso0}, 0);
                check("mid_rst_int1", {31'h0, int1_0}, 0);
                check("mid_rst_int2", {31'h0, int2_0}, 0);
                check("mid_rst_wr_strobe", {31'h0, wr_strobe0}, 0);
                check("mid_rst_wr_addr", {24'h0, wr_addr0}, 0);
                check("mid_rst_wr_data", {24'h0, wr_data0}, 0);
                resetn = 1'b1;
                repeat (100) @(negedge clk);
                check("miso_after_rst", {31'h0, miso0}, 0);
            end
        join
        tx_buf = '{8'h0B, 8'h00}; exp_q.push_back(8'hAD);
        spi_frame(1'b0, 24, 1'b1, "devid_after_rst");
        tx_buf = '{8'h0B, 8'h0E}; exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_frame(1'b0, 32, 1'b1, "axis_after_rst");

        check("rd_queue_empty", exp_q.size(), 0);
        check("wr_queue_empty", sb_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
